// File: rtl/serial_alu_ctrl_if.sv
// Request/response bundle for the bit-serial ALU: operands and op in, status and result out.
interface serial_alu_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output start, op, a, b,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, carry_out
    );
endinterface

// File: rtl/serial_alu_ctrl.sv
// Bit-serial AND/OR/ADD/SUB: one 1-bit slice per cycle, LSB first, WIDTH cycles busy then a one-cycle done.
// start is only sampled in IDLE; operands are captured on acceptance so later input changes are ignored.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    serial_alu_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             b_bit, s_bit, c_nxt, last_bit, accept;

    assign accept   = (state_q == IDLE) && bus.start;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.result    = res_q;
        bus.carry_out = cout_q;
    end

    // 1-bit ALU slice; SUB is ADD of ~b with the carry preset to 1
    always_comb begin
        b_bit = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
        c_nxt = (a_q[0] & b_bit) | (a_q[0] & c_q) | (b_bit & c_q);
        case (op_q)
            OP_AND:  s_bit = a_q[0] & b_q[0];
            OP_OR:   s_bit = a_q[0] | b_q[0];
            default: s_bit = a_q[0] ^ b_bit ^ c_q;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        cout_d = cout_q;
        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            op_d  = bus.op;
            cnt_d = '0;
            c_d   = (bus.op == OP_SUB);
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {s_bit, res_q[WIDTH-1:1]};
            c_d   = c_nxt;
            cnt_d = cnt_q + CW'(1);
            // borrow is the complement of the final carry of a + ~b + 1
            if (last_bit) begin
                case (op_q)
                    OP_ADD:  cout_d = c_nxt;
                    OP_SUB:  cout_d = ~c_nxt;
                    default: cout_d = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            cout_q <= cout_d;
        end
    end
endmodule
